// File: rtl/atari_bus_master.sv
// Atari 7800 bus-cycle initiator: free-running PHI2, one bus cycle per accepted
// command, registered address/RW/HALT/data outputs and a read-response strobe.
module atari_bus_master #(
  parameter int          CYCLE_CLKS = 15,
  parameter int          PHI1_CLKS  = 7,
  parameter int          WDATA_CLK  = 8,
  parameter int          SAMPLE_CLK = 13,
  parameter logic [15:0] IDLE_ADDR  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic        cmd_dma,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic [15:0] a,
  output logic [7:0]  d_out,
  input  logic [7:0]  d_in,
  output logic        d_oe,
  output logic        phi2,
  output logic        rw,
  output logic        halt
);

  localparam logic [4:0] LAST_CNT   = 5'(CYCLE_CLKS - 1);
  localparam logic [4:0] PHI1_CNT   = 5'(PHI1_CLKS);
  localparam logic [4:0] WDATA_CNT  = 5'(WDATA_CLK);
  localparam logic [4:0] SAMPLE_CNT = 5'(SAMPLE_CLK);

  logic [4:0]  cnt;
  logic [4:0]  cnt_nxt;
  logic        slot_rw;
  logic        slot_dma;
  logic [15:0] slot_addr;
  logic [7:0]  slot_wdata;
  logic        act_valid;
  logic [7:0]  act_wdata;
  logic        accept;

  assign accept  = cmd_valid && cmd_ready;
  assign cnt_nxt = (cnt == LAST_CNT) ? 5'd0 : cnt + 5'd1;

  // Outputs are computed from cnt_nxt so each registered output changes
  // exactly when the visible cnt reaches the named count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 5'd0;
      phi2       <= 1'b0;
      rw         <= 1'b1;
      halt       <= 1'b1;
      a          <= IDLE_ADDR;
      d_out      <= 8'h00;
      d_oe       <= 1'b0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      slot_rw    <= 1'b1;
      slot_dma   <= 1'b0;
      slot_addr  <= 16'h0000;
      slot_wdata <= 8'h00;
      act_valid  <= 1'b0;
      act_wdata  <= 8'h00;
    end else begin
      cnt       <= cnt_nxt;
      phi2      <= (cnt_nxt >= PHI1_CNT);
      rsp_valid <= 1'b0;
      if (cnt == LAST_CNT) begin
        d_oe <= 1'b0;
        if (!cmd_ready) begin
          act_valid <= 1'b1;
          a         <= slot_addr;
          rw        <= slot_rw;
          halt      <= !slot_dma;
          act_wdata <= slot_wdata;
          cmd_ready <= 1'b1;
        end else if (cmd_valid) begin
          // Command offered on the wrap clk goes straight into the new cycle.
          act_valid <= 1'b1;
          a         <= cmd_addr;
          rw        <= cmd_rw;
          halt      <= !cmd_dma;
          act_wdata <= cmd_wdata;
        end else begin
          act_valid <= 1'b0;
          a         <= IDLE_ADDR;
          rw        <= 1'b1;
          halt      <= 1'b1;
        end
      end else begin
        if (accept) begin
          slot_rw    <= cmd_rw;
          slot_dma   <= cmd_dma;
          slot_addr  <= cmd_addr;
          slot_wdata <= cmd_wdata;
          cmd_ready  <= 1'b0;
        end
        if (act_valid && !rw && (cnt_nxt == WDATA_CNT)) begin
          d_out <= act_wdata;
          d_oe  <= 1'b1;
        end
        if (act_valid && rw && (cnt == SAMPLE_CNT)) begin
          rsp_data <= d_in;
        end
        if (act_valid && rw && (cnt_nxt == LAST_CNT)) begin
          rsp_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/atari_bus_master.md
Name: atari_bus_master

Overview:
- Synthesizable Atari 7800 bus-cycle initiator. It generates free-running PHI2 from the 27 MHz system clock, plus the address, RW, HALT and write data on the cartridge side.
- Serves as the other end of the cartridge responder. Used in the bring-up and self-test build to exercise cartridge ROM reads, POKEY writes and DMA (HALT-low) reads without a console.
- Takes commands on a valid/ready port, one bus cycle per accepted command, and returns read data on a response strobe.

Parameters:
- CYCLE_CLKS, 15: clk periods per bus cycle (27 MHz / 15 = 1.8 MHz); legal range 8..31.
- PHI1_CLKS, 7: clk periods of PHI2 low at cycle start; PHI2 is high for the remaining CYCLE_CLKS-PHI1_CLKS.
- WDATA_CLK, 8: cycle count at which write data begins driving; must be >= PHI1_CLKS.
- SAMPLE_CLK, 13: cycle count at which read data is captured; must be > PHI1_CLKS and < CYCLE_CLKS-1.
- IDLE_ADDR, 16'h0000: address driven on idle cycles.

Ports:
- clk  in  1  27 MHz system clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command slot empty.
- cmd_rw  in  1  1 = read, 0 = write.
- cmd_dma  in  1  1 = perform the cycle with HALT low.
- cmd_addr  in  16  bus address.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  one-clk pulse: read cycle complete.
- rsp_data  out  8  captured read data, valid with rsp_valid.
- a  out  16  address bus.
- d_out  out  8  data to drive.
- d_in  in  8  data bus input, from the top-level tristate.
- d_oe  out  1  data bus drive enable (1 = drive).
- phi2  out  1  phase-2 clock.
- rw  out  1  read/write.
- halt  out  1  HALT, active low.

Behaviour:
- Reset values: phi2=0, rw=1, halt=1, a=IDLE_ADDR, d_out=0, d_oe=0, cmd_ready=1, rsp_valid=0, rsp_data=0, cycle counter cnt=0, pending slot empty, active cycle cleared.
- Reset mid-cycle aborts the cycle; no response is issued.
- cnt runs 0..CYCLE_CLKS-1 and wraps to 0; it is never stalled.
- phi2 is registered and equals (cnt >= PHI1_CLKS), so PHI2 is free-running whether or not commands are present.
- Command slot is one entry. cmd_ready = slot empty; accept on cmd_valid && cmd_ready. Acceptance on the same clk as the cnt wrap still counts as captured for the next cycle.
- At cnt==0, cycle start:
  - If the slot is full, the command moves to the active register, the slot empties, and a/rw/halt update on this clk: a=cmd_addr, rw=cmd_rw, halt=!cmd_dma.
  - Otherwise it is an idle cycle: a=IDLE_ADDR, rw=1, halt=1, d_oe=0.
- a, rw and halt are held constant for the whole cycle, so they are stable across both PHI2 edges.
- Write cycle: at cnt==WDATA_CLK, d_out=wdata and d_oe=1. d_oe is held through cnt==CYCLE_CLKS-1 and cleared at the next cnt==0, giving hold past the PHI2 fall.
  - d_oe is never 1 during a read or idle cycle.
- Read cycle: rsp_data <= d_in at cnt==SAMPLE_CLK. rsp_valid pulses for 1 clk at cnt==CYCLE_CLKS-1.
  - Latency from cycle start to rsp_valid is CYCLE_CLKS-1 clks.
  - Writes and idle cycles produce no response.
- DMA bursts: back-to-back cmd_dma=1 commands keep halt low continuously with no glitch between cycles. halt returns high at cnt==0 of the first non-DMA or idle cycle.
- Throughput: one command per bus cycle if the next command is accepted before cnt==0. Otherwise one idle cycle is inserted.
- Tristate is resolved at top level: d = d_oe ? d_out : z. The buffer OE/DIR is derived at top level from d_oe/rw.

Test Plan:
- Reset release, no commands for 3 cycles -> phi2 period 15 clks, low 7 / high 8; rw=1, halt=1, a=0000, d_oe=0, no rsp_valid.
- Read $4000 with d_in driven to 8'hA9 during phi2 high -> a=4000 and rw=1 for exactly 15 clks; rsp_valid one clk at cnt 14; rsp_data=A9.
- Write 8'h5C to $0450 -> rw=0; d_oe rises at cnt 8 with d_out=5C and falls at next cnt 0; no rsp_valid; cmd_ready re-asserts after cycle start.
- Three back-to-back DMA reads at $8000/$8001/$8002 -> halt low continuously for 45 clks, three responses with the matching d_in values; halt high on the following idle cycle.
- Command accepted on the same clk as cnt wrap -> executes in the immediately following cycle; a command presented while the slot is full is held (cmd_ready=0) until the slot frees.
- rst asserted at cnt 10 of a write -> d_oe=0, rw=1, halt=1, phi2=0 immediately (async); no response; the slot is empty after release.
